// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter and its clients: host load/unload,
// NTT operand read, NTT write-back, pass control and the single-port bank.
interface mem_port_arbiter_if #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 4
);
    localparam int CW = $clog2(WQ_DEPTH) + 1;

    logic              ntt_start;
    logic              ntt_last;
    logic              ntt_busy;
    logic              ntt_done;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_rdata;
    logic              rd_rvalid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;
    logic              wr_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [CW-1:0]     wq_count;

    // Arbiter side.
    modport slave (
        input  ntt_start, ntt_last,
        output ntt_busy, ntt_done,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        input  rd_req, rd_addr,
        output rd_gnt, rd_rdata, rd_rvalid,
        input  wr_req, wr_addr, wr_wdata,
        output wr_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output wq_count
    );

    // Client / bank side.
    modport master (
        output ntt_start, ntt_last,
        input  ntt_busy, ntt_done,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        output rd_req, rd_addr,
        input  rd_gnt, rd_rdata, rd_rvalid,
        output wr_req, wr_addr, wr_wdata,
        input  wr_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  wq_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port bank arbiter: host access in IDLE, NTT operand reads with a write-back
// queue during a pass, and a drain phase that empties the queue before signalling done.
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, NTT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wq_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0]   wq_data_q [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] wq_valid_q, wq_valid_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    logic                ntt_busy_q, ntt_done_q;
    logic                host_rvalid_q, rd_rvalid_q;

    logic                full, empty, hazard, wr_ready;
    logic                push, pop;
    logic                host_gnt, rd_gnt;
    logic                mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    assign full     = (count_q == CW'(WQ_DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = rst && !full;

    // Reads are never forwarded from the queue, so any pending write to the same
    // address must reach the bank before the read is granted.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            if (wq_valid_q[i] && (wq_addr_q[i] == bus.rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        pop       = 1'b0;
        host_gnt  = 1'b0;
        rd_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.ntt_start) begin
                    state_d = NTT;
                end else if (bus.host_req) begin
                    host_gnt  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = bus.host_we;
                    mem_addr  = bus.host_addr;
                    mem_wdata = bus.host_wdata;
                end
            end
            NTT: begin
                push = bus.wr_req && wr_ready;
                if (full) begin
                    pop = 1'b1;
                end else if (bus.rd_req && !hazard) begin
                    rd_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = bus.rd_addr;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                if (push && bus.ntt_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pop = !empty;
                if (empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wq_addr_q[rd_ptr_q];
            mem_wdata = wq_data_q[rd_ptr_q];
        end

        // Combinational outputs must fall with rst itself, not at the next edge.
        if (!rst) begin
            push      = 1'b0;
            pop       = 1'b0;
            host_gnt  = 1'b0;
            rd_gnt    = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wq_valid_d = wq_valid_q;
        if (pop) begin
            wq_valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wq_valid_d[wr_ptr_q] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wq_valid_q    <= '0;
            ntt_busy_q    <= 1'b0;
            ntt_done_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            rd_rvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wq_valid_q    <= wq_valid_d;
            ntt_busy_q    <= (state_d != IDLE);
            // Pulse once, on the cycle after the final entry leaves during DRAIN.
            ntt_done_q    <= (state_q == DRAIN) && !empty && (count_d == '0);
            host_rvalid_q <= host_gnt && !bus.host_we;
            rd_rvalid_q   <= rd_gnt;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            wq_addr_q[wr_ptr_q] <= bus.wr_addr;
            wq_data_q[wr_ptr_q] <= bus.wr_wdata;
        end
    end

    assign bus.ntt_busy    = ntt_busy_q;
    assign bus.ntt_done    = ntt_done_q;
    assign bus.host_gnt    = host_gnt;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rvalid_q ? bus.mem_rdata : '0;
    assign bus.rd_gnt      = rd_gnt;
    assign bus.rd_rvalid   = rd_rvalid_q;
    assign bus.rd_rdata    = rd_rvalid_q ? bus.mem_rdata : '0;
    assign bus.wr_ready    = wr_ready;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.wq_count    = count_q;
endmodule
